// File: rtl/jmp_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package jmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned     PC_W_DEF       = 8;
  localparam int unsigned     CNT_W_DEF      = 16;
  localparam logic [7:0]      START_ADDR_DEF = 8'h00;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Clear wins over enable; increment stops once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                q <= '0;
    else if (clr)           q <= '0;
    else if (en && q != '1) q <= q + W'(1);
  end

endmodule

// File: rtl/jmp_pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, jump-table indexing,
// overrun detection and a saturating run-cycle counter.
// Optional call/return support with a link register: define JMP_LINK_EN.
module jmp_pc_sequencer
  import jmp_seq_pkg::*;
#(
  parameter int unsigned          PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0]      START_ADDR = PC_W'(START_ADDR_DEF),
  parameter int unsigned          CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             Taken,
  input  logic [2:0]       JmpIdx,
  input  logic [PC_W-1:0]  LutTarget,
  input  logic             Halt,
`ifdef JMP_LINK_EN
  input  logic             Call,
  input  logic             Ret,
`endif
  output logic [2:0]       LutAddr,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             Overrun,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam logic [PC_W-1:0] PC_LAST = '1;

  state_t state;
  logic   start_go;
  logic   in_run;

`ifdef JMP_LINK_EN
  logic [PC_W-1:0] link;
`endif

  // Table index passes straight through so the target arrives in the branch cycle.
  always_comb begin
    LutAddr = JmpIdx;
  end

  // Start is honoured only outside RUN; it also clears the cycle counter.
  always_comb begin
    in_run   = (state == RUN);
    start_go = Start && !in_run;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk (Clk),
    .rst (Reset),
    .clr (start_go),
    .en  (in_run),
    .q   (CycleCnt)
  );

  // State machine with PC update; Running/Done are registered alongside state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      PC      <= START_ADDR;
      Running <= 1'b0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
`ifdef JMP_LINK_EN
      link    <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state   <= RUN;
            PC      <= START_ADDR;
            Overrun <= 1'b0;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        RUN: begin
          if (Halt) begin
            state   <= DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (Stall) begin
            PC <= PC;
`ifdef JMP_LINK_EN
          end else if (Ret) begin
            PC <= link;
          end else if (Call) begin
            PC   <= LutTarget;
            // PC+1 wraps to zero from the last address, which is the saved value there.
            link <= PC + PC_W'(1);
`endif
          end else if (Branch && Taken) begin
            PC <= LutTarget;
          end else if (PC == PC_LAST) begin
            state   <= DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
            Overrun <= 1'b1;
          end else begin
            PC <= PC + PC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jmp_pc_sequencer.sv
// Self-checking bench for jmp_pc_sequencer (counter narrowed to 4 bits so
// saturation is reachable). Call/return scenario runs when JMP_LINK_EN is defined.
module tb_jmp_pc_sequencer;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [7:0]    pc;
    logic          run;
    logic          done;
    logic          ovr;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       st, sl, br, tk, ht;
    logic [7:0] lut;
    logic       ca, rt;
  } stim_t;

  logic          Clk = 1'b0;
  logic          Reset, Start, Stall, Branch, Taken, Halt;
  logic [2:0]    JmpIdx;
  logic [7:0]    LutTarget;
  logic [2:0]    LutAddr;
  logic [7:0]    PC;
  logic          Running, Done, Overrun;
  logic [CW-1:0] CycleCnt;
`ifdef JMP_LINK_EN
  logic          Call, Ret;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jmp_pc_sequencer #(.PC_W(8), .START_ADDR(8'h00), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Branch(Branch),
    .Taken(Taken), .JmpIdx(JmpIdx), .LutTarget(LutTarget), .Halt(Halt),
`ifdef JMP_LINK_EN
    .Call(Call), .Ret(Ret),
`endif
    .LutAddr(LutAddr), .PC(PC), .Running(Running), .Done(Done),
    .Overrun(Overrun), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running sim, required finish");
    $fatal(1);
  end

  function automatic stim_t mk(input logic st, sl, br, tk, ht, input logic [7:0] lut,
                               input logic ca = 1'b0, input logic rt = 1'b0);
    stim_t s;
    s.st = st; s.sl = sl; s.br = br; s.tk = tk; s.ht = ht; s.lut = lut; s.ca = ca; s.rt = rt;
    return s;
  endfunction

  function automatic stim_t nop();
    return mk(0, 0, 0, 0, 0, 8'h00);
  endfunction

  function automatic exp_t xp(input logic [7:0] pc, input logic r, d, o, input int c);
    exp_t e;
    e.pc = pc; e.run = r; e.done = d; e.ovr = o; e.cnt = CW'(c);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.pc = PC; e.run = Running; e.done = Done; e.ovr = Overrun; e.cnt = CycleCnt;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    Start = s.st; Stall = s.sl; Branch = s.br; Taken = s.tk; Halt = s.ht; LutTarget = s.lut;
`ifdef JMP_LINK_EN
    Call = s.ca; Ret = s.rt;
`endif
  endtask

  task automatic test_reset();
    exp_t e, g;
    Reset = 1'b1; JmpIdx = 3'd5;
    drive(nop());
`ifndef JMP_LINK_EN
    drive(nop());
`else
    Call = 1'b0; Ret = 1'b0;
`endif
    sb.push_back(xp(8'h00, 0, 0, 0, 0));
    #2;
    e = sb.pop_front(); g = obs(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_state got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
               g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
    end
    checks++;
    if (LutAddr !== 3'd5) begin
      errors++;
      $display("FAIL reset_lutaddr got %0d exp 5", LutAddr);
    end
    @(posedge Clk); #2; Reset = 1'b0;
    sb.push_back(xp(8'h00, 0, 0, 0, 0));
    @(posedge Clk); #1;
    e = sb.pop_front(); g = obs(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL idle_hold got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
               g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
    end
  endtask

  task automatic test_sequential();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++) begin s.push_back(nop()); x.push_back(xp(8'(i), 1, 0, 0, i)); end
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00)); x.push_back(xp(8'h04, 0, 1, 0, 5));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL seq[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    JmpIdx = 3'b011;
    for (int k = 0; k < 2; k++) begin
      s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
      for (int i = 1; i <= 3; i++) begin s.push_back(nop()); x.push_back(xp(8'(i), 1, 0, 0, i)); end
      if (k == 0) begin
        s.push_back(mk(0, 0, 1, 1, 0, 8'h0F)); x.push_back(xp(8'h0F, 1, 0, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 1, 8'h00)); x.push_back(xp(8'h0F, 0, 1, 0, 5));
      end else begin
        s.push_back(mk(0, 0, 1, 0, 0, 8'h0F)); x.push_back(xp(8'h04, 1, 0, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 1, 8'h00)); x.push_back(xp(8'h04, 0, 1, 0, 5));
      end
    end
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      if (s[i].br) begin
        #1; checks++;
        if (LutAddr !== 3'b011) begin
          errors++;
          $display("FAIL branch_lutaddr[%0d] got %b exp 011", i, LutAddr);
        end
      end
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL branch[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask

  task automatic test_stall_halt();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h01, 1, 0, 0, 1));
    for (int i = 2; i <= 5; i++) begin s.push_back(nop()); x.push_back(xp(8'(i), 1, 0, 0, i)); end
    s.push_back(mk(0, 1, 1, 1, 0, 8'h20)); x.push_back(xp(8'h05, 1, 0, 0, 6));
    s.push_back(mk(0, 0, 1, 1, 1, 8'h20)); x.push_back(xp(8'h05, 0, 1, 0, 7));
    s.push_back(nop());                    x.push_back(xp(8'h05, 0, 1, 0, 7));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL stall_halt[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask

  task automatic test_overrun();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    s.push_back(mk(0, 0, 1, 1, 0, 8'hFF)); x.push_back(xp(8'hFF, 1, 0, 0, 1));
    s.push_back(nop());                    x.push_back(xp(8'hFF, 0, 1, 1, 2));
    s.push_back(nop());                    x.push_back(xp(8'hFF, 0, 1, 1, 2));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL overrun[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    for (int i = 1; i <= 18; i++) begin
      s.push_back(nop()); x.push_back(xp(8'(i), 1, 0, 0, (i > 15) ? 15 : i));
    end
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00)); x.push_back(xp(8'h12, 0, 1, 0, 15));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00)); x.push_back(xp(8'h00, 1, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL saturate[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    for (int i = 1; i <= 5; i++) begin s.push_back(nop()); x.push_back(xp(8'(i), 1, 0, 0, i)); end
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL midrun[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
    #2; Reset = 1'b1;
    sb.push_back(xp(8'h00, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); g = obs(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL async_reset got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
               g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
    end
    #2; Reset = 1'b0;
    sb.push_back(xp(8'h00, 0, 0, 0, 0));
    @(posedge Clk); #1;
    e = sb.pop_front(); g = obs(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL post_reset_idle got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
               g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
    end
  endtask

`ifdef JMP_LINK_EN
  task automatic test_link();
    stim_t s[$]; exp_t x[$]; exp_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 8'h00));       x.push_back(xp(8'h00, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 0, 8'h10));       x.push_back(xp(8'h10, 1, 0, 0, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h3F, 1, 0)); x.push_back(xp(8'h3F, 1, 0, 0, 2));
    s.push_back(nop());                          x.push_back(xp(8'h40, 1, 0, 0, 3));
    s.push_back(nop());                          x.push_back(xp(8'h41, 1, 0, 0, 4));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1)); x.push_back(xp(8'h11, 1, 0, 0, 5));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h55, 1, 1)); x.push_back(xp(8'h11, 1, 0, 0, 6));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1)); x.push_back(xp(8'h11, 1, 0, 0, 7));
    s.push_back(mk(0, 0, 1, 1, 0, 8'hFF));       x.push_back(xp(8'hFF, 1, 0, 0, 8));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h30, 1, 0)); x.push_back(xp(8'h30, 1, 0, 0, 9));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1)); x.push_back(xp(8'h00, 1, 0, 0, 10));
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00));       x.push_back(xp(8'h00, 0, 1, 0, 11));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(x[i]);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL link[%0d] got pc=%h r=%b d=%b o=%b c=%0d exp pc=%h r=%b d=%b o=%b c=%0d",
                 i, g.pc, g.run, g.done, g.ovr, g.cnt, e.pc, e.run, e.done, e.ovr, e.cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_halt();
    test_overrun();
    test_saturate();
    test_reset_midrun();
`ifdef JMP_LINK_EN
    test_link();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
